// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, read-only cache controller with 4-word lines.
// A request is captured in IDLE, checked in LOOKUP, and on a miss the whole line
// is refilled from main memory one word per accepted mem_ready beat.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined;
// otherwise hit_cnt/miss_cnt are tied to zero and no counter registers exist.
//
// Handshakes:
//   cpu side : a request is taken on a rising edge where cpu_rdy=1 and cpu_req=1;
//              cpu_ack is a single-cycle pulse during which cpu_rdata is valid.
//   mem side : while mem_rd=1, each rising edge with mem_ready=1 consumes
//              mem_rdata for the current mem_adr; mem_ready=0 stalls indefinitely.
module cache_ctrl #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 3,
  localparam int ADDR_W = TAG_W + INDEX_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_adr,
  output logic              cpu_rdy,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [1:0]        dbg_state
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_REFILL  = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [1:0]          beat_q, beat_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [LINES-1:0]    valid_q, valid_d;

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]    tag_mem_q  [LINES];
  logic [31:0]         data_mem_q [LINES][4];
  logic                data_we;
  logic                tag_we;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [1:0]          req_off;
  logic                lookup_hit;
  logic [31:0]         line_word;

  assign req_tag = adr_q[ADDR_W-1:INDEX_W+2];
  assign req_idx = adr_q[INDEX_W+1:2];
  assign req_off = adr_q[1:0];

  assign lookup_hit = valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag);
  assign line_word  = data_mem_q[req_idx][req_off];

  // State, captured address, beat counter, response and valid-bit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      beat_q  <= 2'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: request capture, hit/miss decision and refill sequencing.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    valid_d = valid_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          adr_d   = cpu_adr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          ack_d   = 1'b1;
          rdata_d = line_word;
          state_d = S_IDLE;
        end else begin
          beat_d  = 2'd0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          data_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            // Words 0..2 are already in the array; word 3 is only on the bus now.
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            ack_d            = 1'b1;
            rdata_d          = (req_off == 2'd3) ? mem_rdata : line_word;
            state_d          = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line storage writes during refill beats.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem_q[req_idx][beat_q] <= mem_rdata;
    end
    if (tag_we) begin
      tag_mem_q[req_idx] <= req_tag;
    end
  end

  assign cpu_rdy   = (state_q == S_IDLE);
  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign mem_rd    = (state_q == S_REFILL);
  assign mem_adr   = mem_rd ? {adr_q[ADDR_W-1:2], beat_q} : '0;
  assign dbg_state = state_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters, bumped in the LOOKUP cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl (default parameters).
// Main memory returns 0xA500_0000 | address for every refill word.
module tb_cache_ctrl;

  localparam int AW = 15;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_adr;
  logic          cpu_rdy;
  logic          cpu_ack;
  logic [31:0]   cpu_rdata;
  logic          mem_rd;
  logic [AW-1:0] mem_adr;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
  logic [1:0]    dbg_state;

  logic          mem_en;
  logic [AW-1:0] beat_log[$];

  int tests = 0;
  int fails = 0;

  cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_adr   (cpu_adr),
    .cpu_rdy   (cpu_rdy),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_rd    (mem_rd),
    .mem_adr   (mem_adr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mw(input logic [AW-1:0] a);
    return 32'hA500_0000 | {17'd0, a};
  endfunction

  function automatic logic [31:0] cnt(input int n);
    return STATS ? n : 32'd0;
  endfunction

  // Memory model: combinational word, ready gated by the bench.
  assign mem_ready = mem_en;
  assign mem_rdata = mw(mem_adr);

  // Record every accepted refill beat address.
  always @(negedge clk) begin
    #2;
    if (rst && mem_rd && mem_ready) beat_log.push_back(mem_adr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cpu_req = 1'b0;
    mem_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one read; report data, negedge index at which ack was seen, mem_rd cycles.
  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d,
                         output int ack_edge, output int rd_cyc);
    beat_log.delete();
    @(negedge clk);
    chk("rdy_before_req", cpu_rdy, 1);
    cpu_req = 1'b1;
    cpu_adr = a;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_adr = AW'($urandom_range(0, 32767));
    ack_edge = 0;
    rd_cyc = 0;
    d = '0;
    while (ack_edge < 100) begin
      @(negedge clk);
      #1;
      ack_edge++;
      if (mem_rd) rd_cyc++;
      if (cpu_ack) begin
        d = cpu_rdata;
        break;
      end
    end
    if (!cpu_ack) chk("ack_timeout", cpu_ack, 1);
  endtask

  task automatic chk_beats(input logic [AW-1:0] base);
    chk("beat_count", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("beat_adr", beat_log[i], base + AW'(i));
    end
  endtask

  task automatic chk_pulse();
    @(negedge clk);
    #1;
    chk("ack_one_cycle", cpu_ack, 0);
  endtask

  logic [31:0]   d;
  int            ae;
  int            rc;
  logic [AW-1:0] base;

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0;
    cpu_adr = '0;
    mem_en = 1'b1;

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_state", dbg_state, 0);
    do_reset();
    chk("rdy_after_rst", cpu_rdy, 1);

    // Cold read.
    do_read(15'h0400, d, ae, rc);
    chk("cold_data", d, mw(15'h0400));
    chk("cold_latency", ae, 6);
    chk("cold_rd_cycles", rc, 4);
    chk_beats(15'h0400);
    chk("cold_miss", miss_cnt, cnt(1));
    chk("cold_hit", hit_cnt, cnt(0));
    chk_pulse();

    // Hit on the same line.
    do_read(15'h0401, d, ae, rc);
    chk("hit_data", d, mw(15'h0401));
    chk("hit_latency", ae, 2);
    chk("hit_no_mem_rd", rc, 0);
    chk("hit_hit", hit_cnt, cnt(1));
    chk("hit_miss", miss_cnt, cnt(1));
    chk_pulse();

    // Conflict miss on index 0x100 with tag 1.
    do_read(15'h1401, d, ae, rc);
    chk("conf_data", d, mw(15'h1401));
    chk("conf_latency", ae, 6);
    chk_beats(15'h1400);
    chk("conf_miss", miss_cnt, cnt(2));

    // Evicted line must miss again.
    do_read(15'h0401, d, ae, rc);
    chk("reread_data", d, mw(15'h0401));
    chk("reread_rd_cycles", rc, 4);
    chk("reread_miss", miss_cnt, cnt(3));

    // Requested word is the one returned in the final beat.
    do_read(15'h1403, d, ae, rc);
    chk("lastbeat_data", d, mw(15'h1403));
    chk("lastbeat_miss", miss_cnt, cnt(4));
    chk("lastbeat_hit", hit_cnt, cnt(1));

    // Backpressure on beat 2, then reset before the last beat.
    base = 15'h2808;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_adr = base;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_lookup_state", dbg_state, 1);
    chk("bp_rdy_busy", cpu_rdy, 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      #1;
      chk("bp_beat_adr", mem_adr, base + AW'(b));
    end
    mem_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_hold_adr", mem_adr, base + AW'(2));
      chk("bp_hold_rd", mem_rd, 1);
    end
    mem_en = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_beat3_adr", mem_adr, base + AW'(3));
    rst = 1'b0;
    #1;
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_mem_adr", mem_adr, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_ack", cpu_ack, 0);
    chk("abort_rdata", cpu_rdata, 0);
    chk("abort_miss", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    do_read(base, d, ae, rc);
    chk("abort_reread_rd", rc, 4);
    chk("abort_reread_data", d, mw(base));
    chk("abort_reread_miss", miss_cnt, cnt(1));

    // Sequential sweep from a clean reset.
    do_reset();
    for (int a = 1024; a <= 9215; a++) begin
      do_read(AW'(a), d, ae, rc);
      chk("sweep_data", d, mw(AW'(a)));
    end
    @(negedge clk);
    #1;
    chk("sweep_hit", hit_cnt, cnt(6144));
    chk("sweep_miss", miss_cnt, cnt(2048));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 10, SHALL set the index width; the cache holds 2^INDEX_W lines.
REQ-002 Parameter TAG_W, default 3, SHALL set the tag width; ADDR_W = TAG_W+INDEX_W+2, which is 15 by default.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 cpu_req  in  1  SHALL be the read request, sampled only while cpu_rdy=1.
REQ-006 cpu_adr  in  ADDR_W  SHALL be the word address, split as {tag[ADDR_W-1:12], index[11:2], word_offset[1:0]}.
REQ-007 cpu_rdy  out  1  SHALL be high exactly when the controller can accept a request.
REQ-008 cpu_ack  out  1  SHALL be a one-cycle pulse marking cpu_rdata valid.
REQ-009 cpu_rdata  out  32  SHALL carry the requested word.
REQ-010 mem_rd  out  1  SHALL be the refill read strobe to main memory.
REQ-011 mem_adr  out  ADDR_W  SHALL be the refill word address.
REQ-012 mem_ready  in  1  SHALL indicate that mem_rdata is valid for the current mem_adr.
REQ-013 mem_rdata  in  32  SHALL be the refill data word.
REQ-014 hit_cnt  out  32  SHALL be the hit counter.
REQ-015 miss_cnt  out  32  SHALL be the miss counter.

Function
REQ-016 Storage SHALL be direct-mapped: per line one valid bit, a TAG_W tag and 4x32-bit data words, with word 0 at the lowest address.
REQ-017 FSM states SHALL be IDLE, LOOKUP, REFILL and RESPOND; cpu_rdy=1 only in IDLE.
REQ-018 IDLE: cpu_req=1 at edge N SHALL capture cpu_adr and move to LOOKUP; cpu_req=0 SHALL keep the FSM in IDLE.
REQ-019 LOOKUP: valid=1 and tag match SHALL count as a hit: cpu_ack=1 with cpu_rdata=data[word_offset] in cycle N+2, then return to IDLE.
REQ-020 LOOKUP: valid=0 or tag mismatch SHALL count as a miss and go to REFILL with beat=0.
REQ-021 REFILL: mem_rd=1 with mem_adr={tag,index,beat}.
REQ-022 On each cycle with mem_ready=1, mem_rdata SHALL be stored into word[beat] and beat SHALL increment.
REQ-023 mem_ready=0 SHALL hold mem_rd, mem_adr and beat unchanged, with no timeout.
REQ-024 After beat 3 is accepted, the line's tag SHALL be written and its valid bit set; the next state is RESPOND.
REQ-025 RESPOND: cpu_ack=1 and cpu_rdata=requested word for one cycle; the word comes from the refilled line, including a word returned in that same final beat; then IDLE.
REQ-026 Miss latency SHALL be 1 cycle after the 4th accepted mem_ready; minimum 6 cycles from acceptance.
REQ-027 A conflict miss (valid, tag differs) SHALL overwrite the whole line; there is no write-back (read-only cache).
REQ-028 cpu_req or cpu_adr changes while cpu_rdy=0 SHALL be ignored.
REQ-029 mem_ready outside REFILL SHALL be ignored.
REQ-030 mem_rd SHALL be 0 outside REFILL.
REQ-031 cpu_ack SHALL be 0 outside the hit-return cycle and RESPOND.
REQ-032 The hit and miss counters SHALL be updated in the LOOKUP cycle and SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-033 rst=0 SHALL immediately force: state=IDLE, all valid bits=0, beat=0, cpu_rdy=1 (once released), cpu_ack=0, cpu_rdata=0, mem_rd=0, mem_adr=0, hit_cnt=0, miss_cnt=0.
REQ-034 A reset during REFILL SHALL abort the refill; the partially written line SHALL remain invalid.
REQ-035 Tag and data arrays SHALL not require reset.

Configuration
REQ-036 Macro CACHE_STATS_EN defined: hit_cnt and miss_cnt SHALL be implemented per REQ-032.
REQ-037 Macro CACHE_STATS_EN undefined: no counter registers; hit_cnt and miss_cnt SHALL be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-038 Cold read: reset, read 0x0400 -> mem_adr 0x0400..0x0403 over 4 beats, cpu_ack with mem word 0x0400, miss_cnt=1.
REQ-039 Hit: then read 0x0401 -> no mem_rd, cpu_ack at N+2 with word 0x0401, hit_cnt=1.
REQ-040 Conflict: then read 0x1401 (index 0x100, tag 1) -> refill 0x1400..0x1403, miss_cnt=2; a re-read of 0x0401 SHALL then miss.
REQ-041 Sweep: sequential reads 1024..9215 -> hit_cnt=6144, miss_cnt=2048, i.e. 75.0% hit rate (CACHE_STATS_EN defined).
REQ-042 Backpressure and reset: hold mem_ready=0 for 5 cycles on beat 2 -> mem_adr stable; assert rst mid-refill -> line invalid, the next read of the same address misses.
